buffered_router: RTL

BUFFERED_ROUTER -- requirements
Module: buffered_router

---
 rtl/buffered_router.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/buffered_router.sv
`default_nettype none
// ============================================================================
//  Module   : buffered_router (with buffered_router_pkg)
//  Brief    : Mesh router node with per-input FIFOs, dimension-order routing
//             and per-output round-robin packet arbitration.
//  Revision : 1.0 - initial release
// ============================================================================

package buffered_router_pkg;
   localparam int ADDR_W    = 4;
   localparam int PAYLOAD_W = 16;

   typedef enum logic [1:0] {
      FLIT_HEADER = 2'd1,
      FLIT_BODY   = 2'd2,
      FLIT_TAIL   = 2'd3
   } flit_type_e;

   typedef struct packed {
      logic [ADDR_W-1:0] x;
      logic [ADDR_W-1:0] y;
   } addr_t;

   typedef struct packed {
      flit_type_e           ftype;
      addr_t                dst_addr;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   typedef enum logic [2:0] {
      DIR_NORTH = 3'd0,
      DIR_SOUTH = 3'd1,
      DIR_EAST  = 3'd2,
      DIR_WEST  = 3'd3,
      DIR_LOCAL = 3'd4
   } e_dir;
endpackage

module buffered_router
   import buffered_router_pkg::*;
#(
   parameter int X     = 1,
   parameter int Y     = 1,
   parameter int PORTS = 5,
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  flit_t in_flit    [PORTS],
   input  logic  in_enable  [PORTS],
   output logic  in_ack     [PORTS],
   output flit_t out_flit   [PORTS],
   output logic  out_enable [PORTS],
   input  logic  out_ack    [PORTS],
   output logic  drop_pulse
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = $clog2(PORTS);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } out_state_e;

   // FIFO storage and pointers
   flit_t            mem_q    [PORTS][DEPTH];
   flit_t            mem_d    [PORTS][DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [PORTS];
   logic [PTR_W-1:0] wr_ptr_d [PORTS];
   logic [PTR_W-1:0] rd_ptr_q [PORTS];
   logic [PTR_W-1:0] rd_ptr_d [PORTS];
   logic [CNT_W-1:0] cnt_q    [PORTS];
   logic [CNT_W-1:0] cnt_d    [PORTS];

   // Per-input bookkeeping: owned by an output, or draining a self-addressed packet
   logic busy_q [PORTS];
   logic busy_d [PORTS];
   logic drop_q [PORTS];
   logic drop_d [PORTS];

   // Per-output arbitration state
   out_state_e       state_q [PORTS];
   out_state_e       state_d [PORTS];
   logic [IDX_W-1:0] owner_q [PORTS];
   logic [IDX_W-1:0] owner_d [PORTS];
   logic [IDX_W-1:0] last_q  [PORTS];
   logic [IDX_W-1:0] last_d  [PORTS];

   // Holds in_ack low until the first edge after reset release
   logic ready_q;
   logic ready_d;

   logic  empty      [PORTS];
   logic  full       [PORTS];
   flit_t head       [PORTS];
   e_dir  head_dir   [PORTS];
   logic  push       [PORTS];
   logic  pop        [PORTS];
   logic  drop_start [PORTS];
   logic  drop_cont  [PORTS];
   logic  req        [PORTS][PORTS];
   logic  xfer       [PORTS];
   logic  grant_set  [PORTS];
   logic  release_in [PORTS];
   logic  proto_err_any;

   // Dimension-order routing: resolve column first, then row, else local
   function automatic e_dir route(input addr_t a);
      e_dir d;
      if (int'(a.y) == Y) begin
         if (int'(a.x) > X)      d = DIR_SOUTH;
         else if (int'(a.x) < X) d = DIR_NORTH;
         else                    d = DIR_LOCAL;
      end else if (int'(a.y) > Y) begin
         d = DIR_EAST;
      end else begin
         d = DIR_WEST;
      end
      return d;
   endfunction

   // FIFO status, head decode, drop detection and arbitration requests
   always_comb begin
      ready_d       = 1'b1;
      proto_err_any = 1'b0;
      drop_pulse    = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         empty[i]      = (cnt_q[i] == '0);
         full[i]       = (cnt_q[i] == CNT_W'(DEPTH));
         head[i]       = mem_q[i][rd_ptr_q[i]];
         head_dir[i]   = route(head[i].dst_addr);
         in_ack[i]     = ready_q && !full[i];
         push[i]       = in_enable[i] && in_ack[i];
         drop_start[i] = (PORTS == 4) && !empty[i] && (head[i].ftype == FLIT_HEADER)
                         && !busy_q[i] && !drop_q[i] && (head_dir[i] == DIR_LOCAL);
         drop_cont[i]  = drop_q[i] && !empty[i];
         drop_pulse    = drop_pulse | drop_start[i];
         if (!empty[i] && (head[i].ftype != FLIT_HEADER) && !busy_q[i] && !drop_q[i])
            proto_err_any = 1'b1;
         for (int o = 0; o < PORTS; o++) begin
            req[o][i] = !empty[i] && (head[i].ftype == FLIT_HEADER) && !busy_q[i]
                        && !drop_q[i] && (int'(head_dir[i]) == o);
         end
      end
   end

   // Output datapath: stream the owner's head while granted, zero otherwise
   always_comb begin
      for (int o = 0; o < PORTS; o++) begin
         out_enable[o] = 1'b0;
         out_flit[o]   = '0;
         if (state_q[o] == ST_GRANTED && !empty[owner_q[o]]) begin
            out_enable[o] = 1'b1;
            out_flit[o]   = head[owner_q[o]];
         end
         xfer[o] = out_enable[o] && out_ack[o];
      end
   end

   // Output FSM next state: round-robin grant in IDLE, release on tail transfer
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] sel;
      int               idx;
      for (int i = 0; i < PORTS; i++) begin
         grant_set[i]  = 1'b0;
         release_in[i] = 1'b0;
      end
      for (int o = 0; o < PORTS; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         last_d[o]  = last_q[o];
         found      = 1'b0;
         sel        = '0;
         case (state_q[o])
            ST_IDLE: begin
               for (int k = 1; k <= PORTS; k++) begin
                  idx = (int'(last_q[o]) + k) % PORTS;
                  if (!found && req[o][idx]) begin
                     found = 1'b1;
                     sel   = IDX_W'(idx);
                  end
               end
               if (found) begin
                  state_d[o]     = ST_GRANTED;
                  owner_d[o]     = sel;
                  last_d[o]      = sel;
                  grant_set[sel] = 1'b1;
               end
            end
            ST_GRANTED: begin
               if (xfer[o] && head[owner_q[o]].ftype == FLIT_TAIL) begin
                  state_d[o]             = ST_IDLE;
                  release_in[owner_q[o]] = 1'b1;
               end
            end
            default: state_d[o] = ST_IDLE;
         endcase
      end
   end

   // FIFO pops, pointer/count updates, input ownership and drop tracking
   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         pop[i] = drop_start[i] || drop_cont[i];
         for (int o = 0; o < PORTS; o++) begin
            if (xfer[o] && owner_q[o] == IDX_W'(i))
               pop[i] = 1'b1;
         end
         for (int d = 0; d < DEPTH; d++)
            mem_d[i][d] = mem_q[i][d];
         if (push[i])
            mem_d[i][wr_ptr_q[i]] = in_flit[i];
         wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
         rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
         cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         busy_d[i]   = (busy_q[i] && !release_in[i]) || grant_set[i];
         drop_d[i]   = drop_q[i];
         if (drop_start[i])
            drop_d[i] = 1'b1;
         else if (drop_cont[i] && head[i].ftype == FLIT_TAIL)
            drop_d[i] = 1'b0;
      end
   end

   // FIFO storage carries no reset; validity is tracked by the counters
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Control state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         for (int i = 0; i < PORTS; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
            busy_q[i]   <= 1'b0;
            drop_q[i]   <= 1'b0;
            state_q[i]  <= ST_IDLE;
            owner_q[i]  <= '0;
            last_q[i]   <= '0;
         end
      end else begin
         ready_q  <= ready_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         drop_q   <= drop_d;
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
      end
   end

   // A packet must start with a header; anything else at an unowned head is held and flagged
   a_head_is_header: assert property (@(posedge clk) disable iff (!rst_n) !proto_err_any);

endmodule
`default_nettype wire
